imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time program loader that sits directly upstream of the instruction memory and the riscv core in the top level.
- Accepts a stream of program words over a valid/ready interface and writes them to consecutive imem addresses starting at 0.
- Holds the core in reset while loading, then releases it.
- Owns the imem write port and the core's reset.

Parameters:
- WIDTH, 32, data/instruction word width in bits.
- IADDR, 5, imem word-address width; DEPTH = 2**IADDR words.
- HOLD_CYCLES, 4, cycles core_reset_n stays low after the final write completes; must be >= 1.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a load from IDLE, RUN or ERR.
- in_valid  input  1  stream word valid.
- in_data  input  WIDTH  stream word.
- in_last  input  1  marks the final program word; qualified by in_valid.
- in_ready  output  1  loader can accept a word.
- mem_wr_en  output  1  imem write strobe.
- mem_addr  output  IADDR  imem word address.
- mem_wdata  output  WIDTH  imem write data.
- core_reset_n  output  1  active-low reset to the riscv core.
- done  output  1  high in RUN.
- error  output  1  high in ERR.
- word_count  output  IADDR+1  number of words written in the current or last load.

Behaviour:
- Reset (async, reset_n=0): state=IDLE; in_ready=0, mem_wr_en=0, mem_addr=0, mem_wdata=0, core_reset_n=0, done=0, error=0, word_count=0, hold counter=0.
- States: IDLE, LOAD, HOLD, RUN, ERR, plus CHK when the macro is defined. All outputs are registered except in_ready, which is decoded from state.
- IDLE:
  - core_reset_n=0, in_ready=0.
  - start -> LOAD; word_count cleared to 0.
- LOAD:
  - in_ready=1. A handshake is in_valid && in_ready at the rising edge.
  - On a handshake: next cycle mem_wr_en=1, mem_addr=word_count[IADDR-1:0], mem_wdata=in_data, and word_count increments by 1.
  - Write latency is 1 cycle; back-to-back handshakes give back-to-back writes.
  - mem_wr_en=0 in any cycle without a preceding handshake.
  - Handshake with in_last=1 -> HOLD (or CHK if the macro is defined).
  - Handshake without in_last at index DEPTH-1 -> ERR. That word is still written; the program is too long.
  - start is ignored in LOAD.
- HOLD:
  - in_ready=0, core_reset_n=0.
  - Hold counter counts HOLD_CYCLES cycles, then -> RUN.
- RUN:
  - core_reset_n=1, done=1, in_ready=0.
  - start -> LOAD; core_reset_n=0 and done=0 on the next cycle, and word_count is cleared.
- ERR:
  - error=1 (sticky), core_reset_n=0, in_ready=0.
  - start -> LOAD; error clears.
- Boundary conditions:
  - in_valid while not in LOAD: ignored, no write.
  - in_last on word index DEPTH-1 is legal -> HOLD; word_count=DEPTH.
  - An empty program is impossible: at least one word is required.
  - reset_n asserted mid-load: immediate return to the reset values; partially written imem contents are not cleared.
  - mem_addr and mem_wdata hold their last values when mem_wr_en=0.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - After the in_last handshake, enter CHK with in_ready=1.
  - The next handshake word is a checksum and is not written to imem.
  - It is compared with the running sum of all program words, modulo 2**WIDTH.
  - Match -> HOLD; mismatch -> ERR.
  - The running sum is cleared on entry to LOAD.
- Undefined:
  - No CHK state and no sum register; in_last goes directly to HOLD.

Test Plan:
- Reset, start, stream 3 words 0x00500093, 0x00A00113, 0x002081B3 (last on the third) with in_valid held high -> writes at addr 0,1,2 on consecutive cycles; word_count=3; core_reset_n rises exactly 4 cycles after the HOLD entry cycle; done=1.
- Same stream with in_valid toggling 1,0,1,0,1 -> mem_wr_en only the cycle after each handshake; addresses 0,1,2 with no gaps or duplicates.
- Stream 32 words with no in_last -> word 31 written at addr 31; error=1; core_reset_n stays 0; start then restarts the load at addr 0 and error clears.
- In RUN, pulse start -> core_reset_n=0 and done=0 the next cycle; a new 1-word program 0x00000013 is written at addr 0 and word_count=1.
- Assert reset_n low during the 2nd word of a load -> all outputs return to reset values asynchronously; state is IDLE.
- With IMEM_LOADER_CHECKSUM_EN, stream words 1, 2, 3 then checksum 6 -> RUN. A second run with checksum 7 -> ERR; the checksum word is never written.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: boot-time loader that writes a valid/ready word stream into imem from address 0
// and holds the core in reset until loading completes. Define IMEM_LOADER_CHECKSUM_EN for a trailing checksum word.
module imem_loader #(
    parameter int WIDTH       = 32,
    parameter int IADDR       = 5,
    parameter int HOLD_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             mem_wr_en,
    output logic [IADDR-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             core_reset_n,
    output logic             done,
    output logic             error,
    output logic [IADDR:0]   word_count
);

    localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(HOLD_CYCLES - 1);
    localparam logic [IADDR:0] LAST_IDX  = {1'b0, {IADDR{1'b1}}};

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HOLD, S_RUN, S_ERR, S_CHK} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HOLD, S_RUN, S_ERR} state_t;
`endif

    state_t           state_q, state_d;
    logic             mem_wr_en_q, mem_wr_en_d;
    logic [IADDR-1:0] mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic             core_reset_n_q, core_reset_n_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
    logic [IADDR:0]   word_count_q, word_count_d;
    logic [HCW-1:0]   hold_cnt_q, hold_cnt_d;
    logic             handshake;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [WIDTH-1:0] sum_q, sum_d;
`endif

    always_comb begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        in_ready = (state_q == S_LOAD) || (state_q == S_CHK);
`else
        in_ready = (state_q == S_LOAD);
`endif
    end

    assign handshake = in_valid && in_ready;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d      = state_q;
        mem_wr_en_d  = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        word_count_d = word_count_q;
        hold_cnt_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d        = sum_q;
`endif

        case (state_q)
            S_IDLE, S_RUN, S_ERR: begin
                if (start) begin
                    state_d      = S_LOAD;
                    word_count_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d        = '0;
`endif
                end
            end
            S_LOAD: begin
                if (handshake) begin
                    mem_wr_en_d  = 1'b1;
                    mem_addr_d   = word_count_q[IADDR-1:0];
                    mem_wdata_d  = in_data;
                    word_count_d = word_count_q + (IADDR+1)'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d        = sum_q + in_data;
                    if (in_last) state_d = S_CHK;
`else
                    if (in_last) state_d = S_HOLD;
`endif
                    // The word at the last address is still written before declaring overflow.
                    else if (word_count_q == LAST_IDX) state_d = S_ERR;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHK: begin
                if (handshake) state_d = (in_data == sum_q) ? S_HOLD : S_ERR;
            end
`endif
            S_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) state_d = S_RUN;
                else hold_cnt_d = hold_cnt_q + HCW'(1);
            end
            default: state_d = S_IDLE;
        endcase

        // Status flags are registered copies of the next state, so they change together with it.
        core_reset_n_d = (state_d == S_RUN);
        done_d         = (state_d == S_RUN);
        error_d        = (state_d == S_ERR);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            mem_wr_en_q    <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            core_reset_n_q <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            word_count_q   <= '0;
            hold_cnt_q     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q          <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q        <= state_d;
            mem_wr_en_q    <= mem_wr_en_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            core_reset_n_q <= core_reset_n_d;
            done_q         <= done_d;
            error_q        <= error_d;
            word_count_q   <= word_count_d;
            hold_cnt_q     <= hold_cnt_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q          <= sum_d;
`endif
        end
    end

    assign mem_wr_en    = mem_wr_en_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign core_reset_n = core_reset_n_q;
    assign done         = done_q;
    assign error        = error_q;
    assign word_count   = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized self-checking bench for imem_loader with a write scoreboard.
// Honours IMEM_LOADER_CHECKSUM_EN to exercise the checksum word.
`timescale 1ns/1ps
module tb_imem_loader;

    localparam int WIDTH       = 32;
    localparam int IADDR       = 5;
    localparam int DEPTH       = 32;
    localparam int HOLD_CYCLES = 4;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_last = 1'b0;
    logic             in_ready;
    logic             mem_wr_en;
    logic [IADDR-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic             core_reset_n;
    logic             done;
    logic             error;
    logic [IADDR:0]   word_count;

    imem_loader #(.WIDTH(WIDTH), .IADDR(IADDR), .HOLD_CYCLES(HOLD_CYCLES)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .core_reset_n(core_reset_n), .done(done), .error(error), .word_count(word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IADDR-1:0] addr;
        logic [WIDTH-1:0] data;
        int               due;
    } wr_t;

    wr_t              exp_q[$];
    int               n_checks = 0;
    int               n_errors = 0;
    int               cyc = 0;
    logic [WIDTH-1:0] prog [0:DEPTH-1];
    logic [WIDTH-1:0] csum_delta = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every write must match the oldest expected write, on the cycle it is due.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (reset_n && mem_wr_en) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with nothing expected", mem_addr, mem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 64'(mem_addr), 64'(e.addr));
                    check("wr_data", 64'(mem_wdata), 64'(e.data));
                    check("wr_cycle", 64'(cyc), 64'(e.due));
                end
            end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
                e = exp_q.pop_front();
                n_checks++;
                n_errors++;
                $display("FAIL missed_write: addr 0x%0h data 0x%0h never written", e.addr, e.data);
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge right after the handshake edge.
    task automatic send_word(input logic [WIDTH-1:0] d, input bit last, input int addr,
                             input bit expect_write, output bit ok);
        int  waited;
        wr_t e;
        waited   = 0;
        ok       = 1'b1;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (in_ready !== 1'b1) begin
            if (waited == 20) begin
                n_checks++;
                n_errors++;
                $display("FAIL in_ready_timeout: got 0 expected 1 within 20 cycles");
                ok       = 1'b0;
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
            waited++;
            @(negedge clk);
        end
        if (expect_write) begin
            e.addr = addr[IADDR-1:0];
            e.data = d;
            e.due  = cyc + 1;
            exp_q.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Positioned one cycle after the HOLD entry edge: core stays in reset for HOLD_CYCLES cycles.
    task automatic check_hold_release(input int n);
        for (int k = 1; k <= HOLD_CYCLES + 1; k++) begin
            if (k > 1) @(negedge clk);
            if (k <= HOLD_CYCLES) begin
                check("hold_core_reset_n", 64'(core_reset_n), 64'(0));
                check("hold_done", 64'(done), 64'(0));
                check("hold_in_ready", 64'(in_ready), 64'(0));
            end else begin
                check("run_core_reset_n", 64'(core_reset_n), 64'(1));
                check("run_done", 64'(done), 64'(1));
            end
        end
        check("word_count", 64'(word_count), 64'(n));
        check("error_low", 64'(error), 64'(0));
        check("sb_drained", 64'(exp_q.size()), 64'(0));
    endtask

    // Model: a program of n words lands at addresses 0..n-1; without in_last it stops after DEPTH words.
    task automatic run_program(input int n, input bit has_last, input int gap);
        bit               ok;
        logic [WIDTH-1:0] sum;
        int               len;
        sum = '0;
        len = has_last ? n : DEPTH;
        for (int i = 0; i < len; i++) begin
            int g;
            send_word(prog[i], has_last && (i == len - 1), i, 1'b1, ok);
            if (!ok) return;
            sum = sum + prog[i];
            if (i != len - 1) begin
                g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
                repeat (g) @(negedge clk);
            end
        end
        if (!has_last) begin
            check("ovf_error", 64'(error), 64'(1));
            check("ovf_core_reset_n", 64'(core_reset_n), 64'(0));
            check("ovf_word_count", 64'(word_count), 64'(DEPTH));
            in_valid = 1'b1;
            for (int k = 0; k < 3; k++) begin
                @(negedge clk);
                check("ovf_in_ready", 64'(in_ready), 64'(0));
                check("ovf_no_write", 64'(mem_wr_en), 64'(0));
            end
            in_valid = 1'b0;
            check("ovf_error_sticky", 64'(error), 64'(1));
            return;
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(sum + csum_delta, 1'b0, 0, 1'b0, ok);
        if (!ok) return;
        if (csum_delta != '0) begin
            check("csum_bad_error", 64'(error), 64'(1));
            check("csum_bad_core_reset_n", 64'(core_reset_n), 64'(0));
            check("csum_bad_word_count", 64'(word_count), 64'(n));
            @(negedge clk);
            check("csum_bad_sb_drained", 64'(exp_q.size()), 64'(0));
            return;
        end
`endif
        check_hold_release(n);
    endtask

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'(0));
        check("rst_mem_wr_en", 64'(mem_wr_en), 64'(0));
        check("rst_mem_addr", 64'(mem_addr), 64'(0));
        check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
        check("rst_core_reset_n", 64'(core_reset_n), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_error", 64'(error), 64'(0));
        check("rst_word_count", 64'(word_count), 64'(0));
        reset_n = 1'b1;

        // in_valid in IDLE is ignored
        in_valid = 1'b1;
        in_data  = 32'hDEADBEEF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("idle_in_ready", 64'(in_ready), 64'(0));
            check("idle_no_write", 64'(mem_wr_en), 64'(0));
        end
        in_valid = 1'b0;

        // Three words back to back
        prog[0] = 32'h00500093;
        prog[1] = 32'h00A00113;
        prog[2] = 32'h002081B3;
        pulse_start();
        run_program(3, 1'b1, 0);

        // in_valid in RUN is ignored
        in_valid = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("run_no_write", 64'(mem_wr_en), 64'(0));
        end
        in_valid = 1'b0;

        // Restart from RUN, same words with in_valid toggling
        pulse_start();
        check("restart_core_reset_n", 64'(core_reset_n), 64'(0));
        check("restart_done", 64'(done), 64'(0));
        check("restart_word_count", 64'(word_count), 64'(0));
        run_program(3, 1'b1, 1);

        // Overflow: DEPTH words with no in_last
        for (int i = 0; i < DEPTH; i++) prog[i] = $urandom;
        pulse_start();
        run_program(DEPTH, 1'b0, 0);

        // Restart from ERR with a one-word program, then again from RUN
        prog[0] = 32'h00000013;
        pulse_start();
        check("err_restart_error", 64'(error), 64'(0));
        run_program(1, 1'b1, 0);
        pulse_start();
        check("run_restart_done", 64'(done), 64'(0));
        run_program(1, 1'b1, 0);

        // in_last on the final address is legal
        for (int i = 0; i < DEPTH; i++) prog[i] = $urandom;
        pulse_start();
        run_program(DEPTH, 1'b1, 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Checksum 6 matches 1+2+3; checksum 7 does not
        prog[0] = 32'd1;
        prog[1] = 32'd2;
        prog[2] = 32'd3;
        pulse_start();
        run_program(3, 1'b1, 0);
        csum_delta = 32'd1;
        pulse_start();
        run_program(3, 1'b1, 0);
        csum_delta = '0;
`endif

        // Randomized programs with random valid gaps
        for (int t = 0; t < 10; t++) begin
            bit has_last;
            int n;
            has_last = ($urandom_range(0, 3) != 0);
            n        = has_last ? int'($urandom_range(1, DEPTH)) : DEPTH;
            for (int i = 0; i < DEPTH; i++) prog[i] = $urandom;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_delta = ($urandom_range(0, 2) == 0) ? WIDTH'($urandom_range(1, 255)) : '0;
`endif
            pulse_start();
            run_program(n, has_last, -1);
        end
        csum_delta = '0;

        // Reset asserted during the second word of a load
        begin
            bit ok;
            prog[0] = 32'h11111111;
            pulse_start();
            send_word(prog[0], 1'b0, 0, 1'b1, ok);
            in_valid = 1'b1;
            in_data  = 32'h22222222;
            #2 reset_n = 1'b0;
            #1;
            check("mid_rst_in_ready", 64'(in_ready), 64'(0));
            check("mid_rst_mem_wr_en", 64'(mem_wr_en), 64'(0));
            check("mid_rst_mem_addr", 64'(mem_addr), 64'(0));
            check("mid_rst_mem_wdata", 64'(mem_wdata), 64'(0));
            check("mid_rst_core_reset_n", 64'(core_reset_n), 64'(0));
            check("mid_rst_done", 64'(done), 64'(0));
            check("mid_rst_error", 64'(error), 64'(0));
            check("mid_rst_word_count", 64'(word_count), 64'(0));
            in_valid = 1'b0;
            @(negedge clk);
            reset_n = 1'b1;
            in_valid = 1'b1;
            repeat (2) begin
                @(negedge clk);
                check("post_rst_idle_in_ready", 64'(in_ready), 64'(0));
                check("post_rst_no_write", 64'(mem_wr_en), 64'(0));
            end
            in_valid = 1'b0;
        end

        // Recovery after reset
        prog[0] = 32'hCAFEF00D;
        prog[1] = 32'h0BADC0DE;
        pulse_start();
        run_program(2, 1'b1, 0);

        repeat (2) @(negedge clk);
        check("sb_final_drain", 64'(exp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
